pair_arbiter: RTL and testbench
===============================

PAIR_ARBITER -- requirements
Module: pair_arbiter

Interface
REQ-001 Parameter N_REQ, 14, number of neighbor-cell filter requesters.
REQ-002 Parameter PW, 227, pair word width; bit PW-1 is the null flag (1 = no pair).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a frame (one reference cell); sampled only in IDLE.
REQ-006 req_data  input  N_REQ*PW  flattened pair words; requester i at [i*PW +: PW].
REQ-007 req_valid  input  N_REQ  requester i offers a pair.
REQ-008 req_ready  output  N_REQ  one-hot grant; requester i's word is consumed this cycle.
REQ-009 cell_done  input  N_REQ  requester i has no more pairs this frame; may pulse.
REQ-010 pair_out  output  PW  granted pair word toward force pipeline.
REQ-011 pair_valid  output  1  pair_out holds a real pair.
REQ-012 pair_ready  input  1  downstream accepts pair_out this cycle.
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 Effective request i = req_valid[i] AND NOT req_data[i*PW+PW-1]; null-flagged words are never granted.
REQ-016 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when all done flags set and no effective request; DRAIN->DONE when output slot empty; DONE->IDLE unconditionally after one cycle.
REQ-017 Done flags: per-requester sticky bits, set by cell_done[i], cleared on entry to RUN; a same-cycle cell_done with start counts for the new frame.
REQ-018 Grant only in RUN, when the output slot is empty or is being drained (pair_valid AND pair_ready).
REQ-019 Round-robin: search starts at pointer p, ascends and wraps modulo N_REQ; at most one grant per cycle.
REQ-020 After a grant to i, p = (i+1) mod N_REQ; p unchanged when no grant; p = 0 on entering RUN.
REQ-021 Latency: word granted in cycle t appears on pair_out with pair_valid=1 in cycle t+1.
REQ-022 Output slot holds pair_out stable while pair_valid AND NOT pair_ready.
REQ-023 Slot full, pair_ready=1, and an effective request present: load and unload occur in the same cycle; sustained throughput is one pair per cycle.
REQ-024 pair_valid=0 forces pair_out = null word: bit PW-1 = 1, all other bits 0.
REQ-025 frame_done = 1 exactly in DONE; busy = 1 exactly in RUN or DRAIN.
REQ-026 start outside IDLE is ignored; cell_done outside RUN is ignored except per REQ-017.

Reset
REQ-027 reset low: state IDLE, p=0, done flags 0, slot empty, req_ready=0, pair_valid=0, pair_out=null word, busy=0, frame_done=0.
REQ-028 Reset asserted mid-frame discards the slot contents immediately; no frame_done is issued.

Configuration
REQ-029 PAIR_ARBITER_STATS_EN defined: adds outputs pair_count (16 bits, pairs accepted downstream this frame) and stall_count (16 bits, cycles with pair_valid AND NOT pair_ready); both clear on entry to RUN, saturate at 16'hFFFF, and hold through DONE/IDLE; reset to 0.
REQ-030 PAIR_ARBITER_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-031 Shared package holds N_REQ, PW, the null-word constant, and the state enumeration.
REQ-032 Sub-module rr_arbiter (combinational request vector + pointer in, one-hot grant + grant index out); the pointer register stays in pair_arbiter.

Verification
REQ-033 Reset: start=1, then reset low -> IDLE, pair_out bit 226=1, all other outputs 0.
REQ-034 Fairness: all 14 req_valid=1, pair_ready=1 -> grants 0,1,...,13,0 in consecutive cycles; pair_valid continuously 1 from the second cycle.
REQ-035 Backpressure: req 3 and req 7 valid, pair_ready=0 for 5 cycles -> req 3 word held on pair_out, req_ready stays 0; on pair_ready=1, req 7 follows the next cycle.
REQ-036 Null filter: req 5 valid with bit 226=1 -> never granted, pair_valid stays 0.
REQ-037 Frame end: all cell_done pulsed, last pair stalled 2 cycles -> DRAIN held 2 cycles, then frame_done high for exactly 1 cycle, busy drops with it.
REQ-038 Stats (with PAIR_ARBITER_STATS_EN): 10 pairs with 3 stall cycles -> pair_count=10, stall_count=3 at frame_done.

Source files
------------

// File: rtl/pair_arbiter_pkg.sv
// Shared sizes, null-word constant and frame states for the pair arbiter.
package pair_arbiter_pkg;
  localparam int N_REQ = 14;
  localparam int PW    = 227;
  localparam int IDX_W = $clog2(N_REQ);

  typedef logic [PW-1:0] pair_t;

  localparam pair_t NULL_WORD = {1'b1, {(PW-1){1'b0}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/pair_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr_i, wrapping modulo N.
module rr_arbiter
  import pair_arbiter_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int IW = IDX_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!gnt_vld_o && req_i[cand[IW-1:0]]) begin
        gnt_vld_o            = 1'b1;
        gnt_idx_o            = cand[IW-1:0];
        gnt_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pair_arbiter.sv
// Round-robin merge of neighbor-cell pair streams into one registered output slot.
// Optional per-frame counters are built when PAIR_ARBITER_STATS_EN is defined.
module pair_arbiter
  import pair_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [N_REQ*PW-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ-1:0]    cell_done_i,
  output logic [PW-1:0]       pair_out_o,
  output logic                pair_valid_o,
  input  logic                pair_ready_i,
  output logic                busy_o,
  output logic                frame_done_o
`ifdef PAIR_ARBITER_STATS_EN
  ,
  output logic [15:0]         pair_count_o,
  output logic [15:0]         stall_count_o
`endif
);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             slot_vld_q, slot_vld_d;
  pair_t            slot_dat_q, slot_dat_d;

  logic [N_REQ-1:0] eff_req, arb_req, gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld, run_start, busy, unload;

  // A null-flagged word never competes for the slot.
  always_comb begin
    eff_req = '0;
    for (int i = 0; i < N_REQ; i++) eff_req[i] = req_valid_i[i] & ~req_data_i[i*PW+PW-1];
  end

  assign unload    = slot_vld_q & pair_ready_i;
  assign run_start = (state_q == ST_IDLE) && start_i;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign arb_req   = ((state_q == ST_RUN) && (!slot_vld_q || pair_ready_i)) ? eff_req : '0;

  rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_rr (
    .req_i     (arb_req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_RUN;
        ptr_d   = '0;
        done_d  = cell_done_i;
      end
      ST_RUN: begin
        done_d = done_q | cell_done_i;
        if (&done_q && eff_req == '0) state_d = ST_DRAIN;
        if (gnt_vld) ptr_d = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      // Leave as the last pair is taken, so a stalled pair costs exactly its stall cycles.
      ST_DRAIN: if (!slot_vld_q || pair_ready_i) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_dat_d = slot_dat_q;
    if (gnt_vld) begin
      slot_vld_d = 1'b1;
      slot_dat_d = req_data_i[gnt_idx*PW +: PW];
    end else if (pair_ready_i) begin
      slot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      done_q     <= '0;
      slot_vld_q <= 1'b0;
      slot_dat_q <= NULL_WORD;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      slot_vld_q <= slot_vld_d;
      slot_dat_q <= slot_dat_d;
    end
  end

  assign req_ready_o  = gnt;
  assign pair_valid_o = slot_vld_q;
  assign pair_out_o   = slot_vld_q ? slot_dat_q : NULL_WORD;
  assign busy_o       = busy;
  assign frame_done_o = (state_q == ST_DONE);

`ifdef PAIR_ARBITER_STATS_EN
  logic [15:0] pair_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pair_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (run_start) begin
      pair_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (busy) begin
      if (unload && pair_cnt_q != 16'hFFFF) pair_cnt_q <= pair_cnt_q + 16'd1;
      if (slot_vld_q && !pair_ready_i && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign pair_count_o  = pair_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pair_arbiter.sv
// Directed bench for pair_arbiter with a per-cycle frame/slot model and literal spot checks.
module tb_pair_arbiter;
  import pair_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [N_REQ*PW-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    cell_done = '0;
  logic [PW-1:0]       pair_out;
  logic                pair_valid;
  logic                pair_ready = 1'b0;
  logic                busy, frame_done;
`ifdef PAIR_ARBITER_STATS_EN
  logic [15:0]         pair_count, stall_count;
`endif

  pair_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .cell_done_i  (cell_done),
    .pair_out_o   (pair_out),
    .pair_valid_o (pair_valid),
    .pair_ready_i (pair_ready),
    .busy_o       (busy),
    .frame_done_o (frame_done)
`ifdef PAIR_ARBITER_STATS_EN
    ,
    .pair_count_o (pair_count),
    .stall_count_o(stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_word(input int i);
    logic [PW-1:0] w;
    w = '0;
    w[7:0]     = 8'(i + 1);
    w[120 +: 8] = 8'(i * 17);
    w[PW-2]    = 1'b1;
    return w;
  endfunction

  // Model: frame phase 0 idle, 1 run, 2 drain, 3 done; slot is a one-entry buffer.
  int            m_phase = 0;
  int            m_ptr = 0;
  bit [N_REQ-1:0] m_done = '0;
  bit            m_full = 1'b0;
  logic [PW-1:0] m_word = '0;
  int            m_pc = 0, m_sc = 0;

  function automatic int m_grant();
    logic [PW-1:0] w;
    int i;
    if (m_phase != 1) return -1;
    if (m_full && !pair_ready) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      i = (m_ptr + k) % N_REQ;
      w = req_data[i*PW +: PW];
      if (req_valid[i] && !w[PW-1]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_any_eff();
    logic [PW-1:0] w;
    for (int i = 0; i < N_REQ; i++) begin
      w = req_data[i*PW +: PW];
      if (req_valid[i] && !w[PW-1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 0; m_done <= '0; m_full <= 1'b0; m_pc <= 0; m_sc <= 0;
    end else begin
      g = m_grant();
      if (m_phase == 1 || m_phase == 2) begin
        if (m_full && pair_ready && m_pc < 65535) m_pc <= m_pc + 1;
        if (m_full && !pair_ready && m_sc < 65535) m_sc <= m_sc + 1;
      end
      case (m_phase)
        0: if (start) begin
          m_phase <= 1; m_ptr <= 0; m_done <= cell_done; m_pc <= 0; m_sc <= 0;
        end
        1: begin
          m_done <= m_done | cell_done;
          if (m_done == {N_REQ{1'b1}} && !m_any_eff()) m_phase <= 2;
        end
        2: if (!m_full || pair_ready) m_phase <= 3;
        default: m_phase <= 0;
      endcase
      if (g >= 0) begin
        m_full <= 1'b1;
        m_word <= req_data[g*PW +: PW];
        m_ptr  <= (g + 1) % N_REQ;
      end else if (pair_ready) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N_REQ-1:0] er;
    g  = m_grant();
    er = (g >= 0) ? (N_REQ'(1) << g) : '0;
    chk("model_req_ready", PW'(req_ready), PW'(er));
    chk("model_pair_valid", PW'(pair_valid), PW'(m_full));
    chk("model_pair_out", pair_out, m_full ? m_word : NULL_WORD);
    chk("model_busy", PW'(busy), PW'(m_phase == 1 || m_phase == 2));
    chk("model_frame_done", PW'(frame_done), PW'(m_phase == 3));
`ifdef PAIR_ARBITER_STATS_EN
    chk("model_pair_count", PW'(pair_count), PW'(m_pc));
    chk("model_stall_count", PW'(stall_count), PW'(m_sc));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; req_valid = '0; cell_done = '0; pair_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [PW-1:0] null_lit;
  bit seen;
  int grants;

  initial begin
    null_lit = '0;
    null_lit[226] = 1'b1;
    for (int i = 0; i < N_REQ; i++) req_data[i*PW +: PW] = mk_word(i);

    // Reset with start held high.
    start = 1'b1;
    #1 rst_n = 1'b0;
    at_neg();
    chk("rst_pair_out", pair_out, null_lit);
    chk("rst_pair_valid", PW'(pair_valid), '0);
    chk("rst_req_ready", PW'(req_ready), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_frame_done", PW'(frame_done), '0);
    tick();
    start = 1'b0;
    rst_n = 1'b1;

    // Fairness: everyone requests, downstream always ready.
    do_reset();
    begin_frame();
    req_valid = '1;
    pair_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      at_neg();
      chk($sformatf("fair_grant_%0d", c), PW'(req_ready), PW'(N_REQ'(1) << (c % 14)));
      chk($sformatf("fair_valid_%0d", c), PW'(pair_valid), PW'(c > 0));
      if (c == 5) chk("fair_word4", pair_out, mk_word(4));
      tick();
    end

    // Backpressure: req 3 held, then req 7 follows once downstream frees.
    do_reset();
    begin_frame();
    req_valid = (N_REQ'(1) << 3) | (N_REQ'(1) << 7);
    at_neg();
    chk("bp_grant3", PW'(req_ready), PW'(N_REQ'(1) << 3));
    tick();
    req_valid[3] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      at_neg();
      chk($sformatf("bp_hold_%0d", s), pair_out, mk_word(3));
      chk($sformatf("bp_noready_%0d", s), PW'(req_ready), '0);
      tick();
    end
    pair_ready = 1'b1;
    at_neg();
    chk("bp_grant7", PW'(req_ready), PW'(N_REQ'(1) << 7));
    tick();
    pair_ready = 1'b0;
    req_valid = '0;
    at_neg();
    chk("bp_word7", pair_out, mk_word(7));
    tick();
    // Reset mid-frame with a full slot.
    rst_n = 1'b0;
    at_neg();
    chk("midrst_valid", PW'(pair_valid), '0);
    chk("midrst_out", pair_out, null_lit);
    chk("midrst_busy", PW'(busy), '0);
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      at_neg();
      chk("midrst_no_done", PW'(frame_done), '0);
      tick();
    end

    // Null filter.
    do_reset();
    begin_frame();
    req_data[5*PW+PW-1] = 1'b1;
    req_valid = N_REQ'(1) << 5;
    pair_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      at_neg();
      chk("null_no_grant", PW'(req_ready), '0);
      chk("null_no_valid", PW'(pair_valid), '0);
      tick();
    end
    req_valid = '0;
    req_data[5*PW+PW-1] = 1'b0;

    // Frame end with the last pair stalled two cycles; stray start ignored.
    do_reset();
    begin_frame();
    req_valid = N_REQ'(1) << 2;
    cell_done = '1;
    at_neg();
    chk("fe_grant2", PW'(req_ready), PW'(N_REQ'(1) << 2));
    tick();
    req_valid = '0; cell_done = '0;
    at_neg();
    chk("fe_c1_busy", PW'(busy), PW'(1));
    chk("fe_c1_valid", PW'(pair_valid), PW'(1));
    tick();
    start = 1'b1;
    at_neg();
    chk("fe_c2_busy", PW'(busy), PW'(1));
    chk("fe_c2_done", PW'(frame_done), '0);
    tick();
    pair_ready = 1'b1;
    at_neg();
    chk("fe_c3_busy", PW'(busy), PW'(1));
    chk("fe_c3_done", PW'(frame_done), '0);
    tick();
    start = 1'b0;
    at_neg();
    chk("fe_c4_done", PW'(frame_done), PW'(1));
    chk("fe_c4_busy", PW'(busy), '0);
    tick();
    at_neg();
    chk("fe_c5_done", PW'(frame_done), '0);
    tick();

`ifdef PAIR_ARBITER_STATS_EN
    // Ten pairs from requester 0 with three stall cycles.
    do_reset();
    begin_frame();
    req_valid = N_REQ'(1);
    grants = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      pair_ready = !(c == 3 || c == 4 || c == 7);
      at_neg();
      if (req_ready[0]) grants++;
      tick();
      if (grants == 10) req_valid = '0;
    end
    chk("st_grants", PW'(grants), PW'(10));
    pair_ready = 1'b1;
    cell_done = '1;
    tick();
    cell_done = '0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      at_neg();
      if (frame_done) begin
        seen = 1'b1;
        chk("st_pair_count", PW'(pair_count), PW'(10));
        chk("st_stall_count", PW'(stall_count), PW'(3));
      end
      tick();
    end
    chk("st_frame_done_seen", PW'(seen), PW'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
